// File: rtl/delay_pkg.sv
// Shared types and elaboration helpers for the delay_line block.
package delay_pkg;

    // Deferred-sample controller states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dl_state_e;

    // Smallest buffer that still gives a one-bit pointer.
    localparam int MIN_DEPTH = 2;

    // Pointer / delay-select width for a buffer of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth <= MIN_DEPTH) ? 1 : $clog2(depth);
    endfunction

    // A depth is usable only as a power of two, so the pointer wraps naturally.
    function automatic bit depth_legal(input int depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/delay_line_mem.sv
// Circular delay buffer: one write per cycle at wptr, one combinational read
// at wptr - dly. Owns the write pointer and the per-entry valid bits.
module delay_mem
    import delay_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int DW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_vld,
    input  logic [DW-1:0]    dly,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld
);

    logic [DW-1:0]    wptr_q;
    logic [DW-1:0]    wptr_d;
    logic [DW-1:0]    rptr;
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next pointer, next valid vector and read address.
    always_comb begin
        wptr_d         = wptr_q + 1'b1;
        vld_d          = vld_q;
        vld_d[wptr_q]  = wr_vld;
        rptr           = wptr_q - dly;
    end

    // Read port. With dly=0 the wanted sample is the one being written this
    // cycle, which the array does not hold yet, so it is forwarded directly.
    always_comb begin
        if (dly == '0) begin
            rd_data = wr_data;
            rd_vld  = wr_vld;
        end else begin
            rd_data = mem_q[rptr];
            rd_vld  = vld_q[rptr];
        end
    end

    // Pointer and valid bits; valid bits clear on reset so stale data never
    // shows up as valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            vld_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            vld_q  <= vld_d;
        end
    end

    // Data storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/delay_line.sv
// delay_line: transport delay (out1) plus trigger-deferred sample (out2).
// Build option: define DLY_RETRIG_EN to let trig during a pending countdown
// restart it (cancelling the pending capture); otherwise such trigs are ignored.
module delay_line
    import delay_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int DW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    input  logic [DW-1:0]    dly,
    input  logic             trig,
    output logic [WIDTH-1:0] out1,
    output logic             out1_vld,
    output logic [WIDTH-1:0] out2,
    output logic             out2_vld,
    output logic             busy
);

    if (!depth_legal(DEPTH)) begin : g_depth_check
        $error("delay_line: DEPTH must be a power of two >= 2");
    end

`ifdef DLY_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic [WIDTH-1:0] rd_data;
    logic             rd_vld;

    dl_state_e        state_q,    state_d;
    logic [DW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] out1_q,     out1_d;
    logic             out1_vld_q, out1_vld_d;
    logic [WIDTH-1:0] out2_q,     out2_d;
    logic             out2_vld_q, out2_vld_d;
    logic             busy_q,     busy_d;

    delay_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (in_data),
        .wr_vld  (in_vld),
        .dly     (dly),
        .rd_data (rd_data),
        .rd_vld  (rd_vld)
    );

    // Next-state logic for the transport registers and the deferred sampler.
    // A trig on the capture cycle is handled as a trig in WAIT: it reloads
    // when retriggering is built in, otherwise it is dropped.
    always_comb begin
        out1_d     = rd_data;
        out1_vld_d = rd_vld;
        state_d    = state_q;
        cnt_d      = cnt_q;
        out2_d     = out2_q;
        out2_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    cnt_d   = dly;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (RETRIG && trig) begin
                    cnt_d = dly;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out2_d     = in_data;
                    out2_vld_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT);
    end

    // All state and output registers; reset wins over any trig.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out1_q     <= '0;
            out1_vld_q <= 1'b0;
            out2_q     <= '0;
            out2_vld_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out1_q     <= out1_d;
            out1_vld_q <= out1_vld_d;
            out2_q     <= out2_d;
            out2_vld_q <= out2_vld_d;
            busy_q     <= busy_d;
        end
    end

    assign out1     = out1_q;
    assign out1_vld = out1_vld_q;
    assign out2     = out2_q;
    assign out2_vld = out2_vld_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line. The reference keeps the full sample
// history since reset and a scheduled capture edge number for the deferred path.
module tb_delay_line;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 3;

`ifdef DLY_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_vld;
    logic [DW-1:0]    dly;
    logic             trig;
    logic [WIDTH-1:0] out1;
    logic             out1_vld;
    logic [WIDTH-1:0] out2;
    logic             out2_vld;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    // reference state
    int hist_d[$];
    bit hist_v[$];
    int exp_out1     = 0;
    bit exp_out1_vld = 0;
    bit out1_known   = 1;
    int exp_out2     = 0;
    bit exp_out2_vld = 0;
    bit pending      = 0;
    int cap_edge     = 0;

    always #5 clk = ~clk;

    delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .dly      (dly),
        .trig     (trig),
        .out1     (out1),
        .out1_vld (out1_vld),
        .out2     (out2),
        .out2_vld (out2_vld),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the reference by one edge, then check.
    task automatic step(input logic [WIDTH-1:0] d, input logic v, input logic [DW-1:0] dl,
                        input logic tr, input logic rn);
        int e;
        int src;
        in_data = d;
        in_vld  = v;
        dly     = dl;
        trig    = tr;
        rst_n   = rn;
        @(posedge clk);
        if (!rn) begin
            hist_d.delete();
            hist_v.delete();
            exp_out1     = 0;
            exp_out1_vld = 0;
            out1_known   = 1;
            exp_out2     = 0;
            exp_out2_vld = 0;
            pending      = 0;
        end else begin
            hist_d.push_back(int'(d));
            hist_v.push_back(v);
            e   = hist_d.size() - 1;
            src = e - int'(dl);
            if (src >= 0) begin
                exp_out1     = hist_d[src];
                exp_out1_vld = hist_v[src];
                out1_known   = 1;
            end else begin
                exp_out1_vld = 0;
                out1_known   = 0;
            end
            exp_out2_vld = 0;
            if (pending && e == cap_edge) begin
                if (tr && RETRIG) begin
                    cap_edge = e + int'(dl) + 1;
                end else begin
                    exp_out2     = int'(d);
                    exp_out2_vld = 1;
                    pending      = 0;
                end
            end else if (pending) begin
                if (tr && RETRIG) cap_edge = e + int'(dl) + 1;
            end else if (tr) begin
                pending  = 1;
                cap_edge = e + int'(dl) + 1;
            end
        end
        #1;
        check("out1_vld", 32'(out1_vld), 32'(exp_out1_vld));
        if (out1_known) check("out1", 32'(out1), 32'(exp_out1));
        check("out2", 32'(out2), 32'(exp_out2));
        check("out2_vld", 32'(out2_vld), 32'(exp_out2_vld));
        check("busy", 32'(busy), 32'(pending));
    endtask

    initial begin
        int pulses;
        int busy_cycles;

        // reset held with trig and data active
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 3'd3, 1'b1, 1'b0);

        // transport ramp at dly=3 across several pointer wraps
        for (int i = 1; i <= 20; i++) step(WIDTH'(i), 1'b1, 3'd3, 1'b0, 1'b1);

        // dly=0 with random data and valid
        step(4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(WIDTH'($urandom), 1'($urandom), 3'd0, 1'b0, 1'b1);

        // dly=7 straight out of reset: out1_vld must wait for real data
        step(4'h0, 1'b0, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(WIDTH'($urandom), 1'b1, 3'd7, 1'b0, 1'b1);

        // deferred sample, dly=2: one pulse, busy exactly 3 cycles
        pulses      = 0;
        busy_cycles = 0;
        step(WIDTH'($urandom), 1'b1, 3'd2, 1'b1, 1'b1);
        if (busy) busy_cycles++;
        for (int i = 0; i < 6; i++) begin
            step(WIDTH'($urandom), 1'b1, 3'd2, 1'b0, 1'b1);
            if (out2_vld) pulses++;
            if (busy) busy_cycles++;
        end
        check("dly2_pulses", 32'(pulses), 32'd1);
        check("dly2_busy_cycles", 32'(busy_cycles), 32'd3);

        // retrigger at dly=4: trig at k and k+2
        pulses = 0;
        step(WIDTH'($urandom), 1'b1, 3'd4, 1'b1, 1'b1);
        step(WIDTH'($urandom), 1'b1, 3'd4, 1'b0, 1'b1);
        step(WIDTH'($urandom), 1'b1, 3'd4, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(WIDTH'($urandom), 1'b1, 3'd4, 1'b0, 1'b1);
            if (out2_vld) pulses++;
        end
        check("retrig_pulses", 32'(pulses), 32'd1);

        // reset mid-countdown at dly=5
        step(4'h0, 1'b0, 3'd5, 1'b0, 1'b0);
        step(WIDTH'($urandom), 1'b1, 3'd5, 1'b1, 1'b1);
        step(WIDTH'($urandom), 1'b1, 3'd5, 1'b0, 1'b1);
        step(WIDTH'($urandom), 1'b1, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(WIDTH'($urandom), 1'b1, 3'd5, 1'b0, 1'b1);

        // random traffic, including dly changes, retrigs and stray resets
        for (int i = 0; i < 400; i++)
            step(WIDTH'($urandom), 1'($urandom), DW'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 79) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/delay_line.md
# delay_line

Parametrised, synthesizable successor to the team's two-style delay experiment. It provides two cycle-accurate delay forms on one clock. The first is a transport path that captures every input now and presents it later. The second is a deferred-sample path that waits after a trigger and then samples the input. Delay is selectable at run time. The block sits between a data source and any consumer needing aligned or late-sampled data.

## Interface
- WIDTH, 4, data width in bits (≥1)
- DEPTH, 8, delay buffer entries; power of two, ≥2
- DW, $clog2(DEPTH), width of dly (derived, not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low
- in_data  in  WIDTH  input sample
- in_vld  in  1  in_data qualifier
- dly  in  DW  delay select, 0..DEPTH-1; latency = dly+1 cycles
- trig  in  1  starts a deferred sample on out2
- out1  out  WIDTH  transport-delayed data
- out1_vld  out  1  in_vld delayed identically to out1
- out2  out  WIDTH  deferred sample; holds its value between captures
- out2_vld  out  1  one-cycle pulse when out2 updates
- busy  out  1  high while a deferred sample is pending

## Operation
- Transport path:
  - Circular buffer of DEPTH entries; the write pointer advances every cycle regardless of in_vld.
  - After edge k, out1/out1_vld equal in_data/in_vld sampled at edge k-dly.
  - dly=0 gives a plain one-register delay.
  - A change of dly takes effect at the next edge. Skipped or repeated samples are accepted.
  - Buffer valid bits are cleared by reset, so out1_vld stays 0 until genuinely delayed in_vld arrives.
- Deferred path FSM, states IDLE and WAIT:
  - IDLE, trig=1: load counter with dly, latch nothing else, go to WAIT.
  - WAIT, counter≠0: decrement.
  - WAIT, counter=0: out2 ← in_data, out2_vld=1 for one cycle, go to IDLE.
  - dly is sampled only at trig. Changes to dly during WAIT do not affect the pending countdown.
  - trig in WAIT: behaviour set by DLY_RETRIG_EN (see Configuration).
  - trig on the cycle that returns the FSM to IDLE is treated as a trig in WAIT.
  - busy = (state==WAIT).
- Arithmetic: read pointer = wptr − dly modulo DEPTH (natural DW-bit wrap). The counter is DW bits.

## Timing
- Reset values: out1=0, out1_vld=0, out2=0, out2_vld=0, busy=0, wptr=0, state=IDLE, all buffer valid bits 0. Buffer data is not reset.
- Reset asserted mid-countdown aborts the countdown with no out2_vld. Reset has priority over trig.
- out1 latency is exactly dly+1 edges from the sampling edge. Wrap-around at wptr=DEPTH-1→0 must be seamless.
- out2 latency: trig seen at edge k leads to capture at edge k+dly+1, with out2_vld high for the following cycle.
- busy rises the cycle after the trig edge and falls the cycle out2_vld rises.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- DLY_RETRIG_EN defined:
  - trig in WAIT reloads the counter with the current dly; the pending capture is cancelled and no out2_vld is produced for it.
  - A trig on the capture edge cancels that capture.
- DLY_RETRIG_EN undefined:
  - trig in WAIT is ignored; the pending capture completes on schedule.
  - A trig on the capture edge is dropped.

## Structure
- Package delay_pkg holds:
  - state enum {IDLE, WAIT}
  - DEPTH legality check constant
  - helper function for pointer width
- Sub-module delay_mem: DEPTH×WIDTH circular buffer plus valid bits. It has a write port and one combinational read at wptr−dly, and owns wptr. The top level holds output registers and the FSM.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles while driving in_data=4'hF, trig=1. Required: all outputs 0 and busy=0 throughout.
- Transport latency: dly=3, in_vld=1, drive ramp 1,2,3,… Required: out1 shows value v exactly 4 edges after v was sampled; verify across a wptr wrap (≥DEPTH+4 cycles).
- Zero and maximum delay: dly=0, then dly=7 with DEPTH=8. Required: latencies of 1 and 8 cycles; out1_vld rises only once delayed valid data arrives after reset.
- Deferred sample: dly=2, trig pulse at edge k, in_data=k-indexed counter. Required: out2 = value at edge k+3, one out2_vld pulse, busy high for exactly 3 cycles.
- Retrigger: dly=4, trig at k and again at k+2. With DLY_RETRIG_EN: single capture at k+7. Without: single capture at k+5, second trig ignored.
- Reset mid-operation: dly=5, trig at k, rst_n=0 at k+2. Required: no out2_vld, busy=0 after k+2, out2 remains 0.
